// File: rtl/park_gate_arbiter.sv
// -----------------------------------------------------------------------------
// park_gate_arbiter
//   Shares the time-of-day and the parking slot table between the entry and
//   exit gates. Simultaneous gate requests are served round-robin. An entry
//   allocates the lowest free slot and timestamps it. An exit frees the slot
//   and reports the parked duration in minutes, wrapping across midnight.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   hour, minute            current time of day (0..23 / 0..59)
//   entry_req               entry request level, held until grant/reject
//   exit_req, exit_slot     exit request level and the slot being vacated
//   entry_grant/_reject     1-cycle result pulses for the entry gate
//   entry_slot              slot of the last entry grant
//   exit_grant/_reject      1-cycle result pulses for the exit gate
//   duration                parked minutes of the last exit grant
//   occupied, count, full   slot occupancy bitmap, occupied count, lot full
// -----------------------------------------------------------------------------
module park_gate_arbiter #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           hour,
  input  logic [5:0]           minute,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 entry_grant,
  output logic                 entry_reject,
  output logic [SLOT_W-1:0]    entry_slot,
  output logic                 exit_grant,
  output logic                 exit_reject,
  output logic [10:0]          duration,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W:0]      count,
  output logic                 full
);

  localparam logic [10:0] MIN_PER_DAY = 11'd1440;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    EXIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  prio_exit_q, prio_exit_d;     // 1: exit wins the next tie
  logic                  served_exit_q, served_exit_d; // gate being released
  logic [NUM_SLOTS-1:0]  occupied_q, occupied_d;
  logic [SLOT_W:0]       count_q, count_d;
  logic [10:0]           stamp_q [NUM_SLOTS];
  logic [10:0]           stamp_d [NUM_SLOTS];
  logic [SLOT_W-1:0]     entry_slot_q, entry_slot_d;
  logic [10:0]           duration_q, duration_d;
  logic                  entry_grant_q, entry_grant_d;
  logic                  entry_reject_q, entry_reject_d;
  logic                  exit_grant_q, exit_grant_d;
  logic                  exit_reject_q, exit_reject_d;

  logic [10:0]           now;
  logic [10:0]           stamp_sel;
  logic [SLOT_W-1:0]     free_idx;
  logic                  lot_full;

  assign now       = {5'd0, hour} * 11'd60 + {5'd0, minute};
  assign stamp_sel = stamp_q[exit_slot];
  assign lot_full  = (count_q == (SLOT_W+1)'(NUM_SLOTS));

  // Lowest-index free slot. Scanning downward lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied_q[i]) free_idx = SLOT_W'(i);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case; a path that skips an
    // assignment would otherwise infer a latch.
    state_d        = state_q;
    prio_exit_d    = prio_exit_q;
    served_exit_d  = served_exit_q;
    occupied_d     = occupied_q;
    count_d        = count_q;
    stamp_d        = stamp_q;
    entry_slot_d   = entry_slot_q;
    duration_d     = duration_q;
    entry_grant_d  = 1'b0;
    entry_reject_d = 1'b0;
    exit_grant_d   = 1'b0;
    exit_reject_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (entry_req && (!exit_req || !prio_exit_q)) begin
          state_d       = ENTRY;
          served_exit_d = 1'b0;
          prio_exit_d   = 1'b1;
          if (lot_full) begin
            entry_reject_d = 1'b1;
          end else begin
            entry_grant_d        = 1'b1;
            entry_slot_d         = free_idx;
            occupied_d[free_idx] = 1'b1;
            stamp_d[free_idx]    = now;
            count_d              = count_q + 1'b1;
          end
        end else if (exit_req) begin
          state_d       = EXIT;
          served_exit_d = 1'b1;
          prio_exit_d   = 1'b0;
          if (occupied_q[exit_slot]) begin
            exit_grant_d          = 1'b1;
            occupied_d[exit_slot] = 1'b0;
            count_d               = count_q - 1'b1;
            // The 11-bit difference wraps mod 2048; adding 1440 recovers the
            // midnight-crossing duration since the true result is < 1440.
            duration_d = (now >= stamp_sel) ? (now - stamp_sel)
                                            : (now - stamp_sel + MIN_PER_DAY);
          end else begin
            exit_reject_d = 1'b1;
          end
        end
      end
      ENTRY, EXIT: state_d = RELEASE;
      RELEASE: begin
        // Wait for the served gate to drop; the other gate stays pending.
        if (served_exit_q ? !exit_req : !entry_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the timestamp table is reset together with the control state so a
  // reset mid-operation leaves no stale entry behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      prio_exit_q    <= 1'b0;
      served_exit_q  <= 1'b0;
      occupied_q     <= '0;
      count_q        <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) stamp_q[i] <= '0;
      entry_slot_q   <= '0;
      duration_q     <= '0;
      entry_grant_q  <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_grant_q   <= 1'b0;
      exit_reject_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      prio_exit_q    <= prio_exit_d;
      served_exit_q  <= served_exit_d;
      occupied_q     <= occupied_d;
      count_q        <= count_d;
      stamp_q        <= stamp_d;
      entry_slot_q   <= entry_slot_d;
      duration_q     <= duration_d;
      entry_grant_q  <= entry_grant_d;
      entry_reject_q <= entry_reject_d;
      exit_grant_q   <= exit_grant_d;
      exit_reject_q  <= exit_reject_d;
    end
  end

  assign entry_grant  = entry_grant_q;
  assign entry_reject = entry_reject_q;
  assign entry_slot   = entry_slot_q;
  assign exit_grant   = exit_grant_q;
  assign exit_reject  = exit_reject_q;
  assign duration     = duration_q;
  assign occupied     = occupied_q;
  assign count        = count_q;
  assign full         = lot_full;

endmodule
